// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider / tick generator.
// Each channel produces a 50%-duty divided clock and a one-cycle tick, with shadowed divisor reloads.
module clk_div_multi #(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync_clr,
    input  logic [NUM_CH-1:0] div_wr_en,
    input  logic [CNT_W-1:0]  div_wr_data,
    output logic [NUM_CH-1:0] div_pend,
    output logic [NUM_CH-1:0] clk_div,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // A divisor of zero would never reach its terminal count, so it is stored as one.
    function automatic logic [CNT_W-1:0] clamp(input logic [CNT_W-1:0] v);
        return (v == '0) ? ONE : v;
    endfunction

    logic [CNT_W-1:0] wr_val;
    assign wr_val = clamp(div_wr_data);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] act_div;
        logic [CNT_W-1:0] shd_div;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             term;

        // >= rather than == so a divisor shrunk below the running count wraps at once.
        assign term = (cnt >= act_div - ONE);

        // NOTE: the divisor registers are reset too; their reset value is the
        // functional default period, not just a tidy initial state.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt     <= '0;
                act_div <= RST_DIV;
                shd_div <= RST_DIV;
                pend    <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else if (sync_clr) begin
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
                if (div_wr_en[i]) begin
                    act_div <= wr_val;
                    pend    <= 1'b0;
                end else if (pend) begin
                    act_div <= shd_div;
                    pend    <= 1'b0;
                end
            end else if (en[i]) begin
                if (term) begin
                    // NOTE: non-blocking assignments throughout, so every branch
                    // sees the pre-edge cnt/pend values regardless of statement order.
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= 1'b1;
                    if (div_wr_en[i]) begin
                        act_div <= wr_val;
                        pend    <= 1'b0;
                    end else if (pend) begin
                        act_div <= shd_div;
                        pend    <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + ONE;
                    tick_q <= 1'b0;
                    if (div_wr_en[i]) begin
                        shd_div <= wr_val;
                        pend    <= 1'b1;
                    end
                end
            end else begin
                tick_q <= 1'b0;
                // An idle channel has no period boundary to wait for, so it adopts the shadow next clock.
                if (div_wr_en[i]) begin
                    shd_div <= wr_val;
                    pend    <= 1'b1;
                end else if (pend) begin
                    act_div <= shd_div;
                    pend    <= 1'b0;
                end
            end
        end

        assign div_pend[i] = pend;
        assign clk_div[i]  = clk_q;
        assign tick[i]     = tick_q;
    end

endmodule
